// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for load data, extracts and aligns it, and hands results to WB.
// Ports: EX handshake/bus in, data_data_ok/data_rdata, WB handshake/bus out, flush, ID forwarding/stall.
`timescale 1ns/1ps
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  input  logic [108:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         data_data_ok,
  input  logic [31:0]  data_rdata,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [70:0]  ms_to_ws_bus,
  input  logic         ms_flush,
  output logic [4:0]   MEM_dest,
  output logic [31:0]  MEM_result,
  output logic         MEM_stall
);

  typedef struct packed {
    logic        req_issued;
    logic [2:0]  load_op;
    logic [1:0]  rdata_type;
    logic [31:0] rt_value;
    logic        ex;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_ms_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_CANCEL
  } state_t;

  es_ms_t      es_in;
  es_ms_t      ms_r;
  logic        ms_valid;
  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold_buf;
  logic        ms_ready_go;
  logic        capture;
  logic        cancel_req;
  logic [31:0] ld_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] lwl_v;
  logic [31:0] lwr_v;
  logic [31:0] ld_val;
  logic        is_load;
  logic [31:0] final_result;

  assign es_in = es_to_ms_bus;

  assign ms_ready_go =
    (state == S_IDLE && !ms_r.req_issued) ||
    (state == S_WAIT && data_data_ok) ||
    (state == S_HOLD);

  assign ms_allowin = reset ||
    ((!ms_valid || (ms_ready_go && ws_allowin)) &&
     state != S_CANCEL);

  assign capture = es_to_ms_valid && ms_allowin;

  // A flush strands a request when its data has not yet come back,
  // including one being accepted from EX in the same cycle.
  assign cancel_req =
    (state == S_WAIT && !data_data_ok) ||
    (capture && es_in.req_issued);

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_r <= '0;
    end else if (capture) begin
      ms_r <= es_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_buf <= 32'h0;
    end else if (state == S_WAIT && data_data_ok) begin
      hold_buf <= data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CANCEL) begin
      if (data_data_ok) begin
        state_nxt = S_IDLE;
      end
    end else if (ms_flush) begin
      state_nxt = cancel_req ? S_CANCEL : S_IDLE;
    end else if (capture) begin
      state_nxt = es_in.req_issued ? S_WAIT : S_IDLE;
    end else if (state == S_WAIT) begin
      if (data_data_ok) begin
        state_nxt = ws_allowin ? S_IDLE : S_HOLD;
      end
    end else if (state == S_HOLD) begin
      if (ws_allowin) begin
        state_nxt = S_IDLE;
      end
    end
  end

  assign ld_data = data_data_ok ? data_rdata : hold_buf;
  assign ld_h = ms_r.rdata_type[1] ? ld_data[31:16]
                                   : ld_data[15:0];

  always_comb begin
    ld_b  = ld_data[7:0];
    lwl_v = ld_data;
    lwr_v = ld_data;
    unique case (ms_r.rdata_type)
      2'd0: begin
        ld_b  = ld_data[7:0];
        lwl_v = {ld_data[7:0], ms_r.rt_value[23:0]};
        lwr_v = ld_data;
      end
      2'd1: begin
        ld_b  = ld_data[15:8];
        lwl_v = {ld_data[15:0], ms_r.rt_value[15:0]};
        lwr_v = {ms_r.rt_value[31:24], ld_data[31:8]};
      end
      2'd2: begin
        ld_b  = ld_data[23:16];
        lwl_v = {ld_data[23:0], ms_r.rt_value[7:0]};
        lwr_v = {ms_r.rt_value[31:16], ld_data[31:16]};
      end
      2'd3: begin
        ld_b  = ld_data[31:24];
        lwl_v = ld_data;
        lwr_v = {ms_r.rt_value[31:8], ld_data[31:24]};
      end
    endcase
  end

  always_comb begin
    ld_val = ld_data;
    unique case (ms_r.load_op)
      3'd0: ld_val = ld_data;
      3'd1: ld_val = {{24{ld_b[7]}}, ld_b};
      3'd2: ld_val = {24'h0, ld_b};
      3'd3: ld_val = ms_r.rdata_type[0] ? 32'h0
                   : {{16{ld_h[15]}}, ld_h};
      3'd4: ld_val = ms_r.rdata_type[0] ? 32'h0
                   : {16'h0, ld_h};
      3'd5: ld_val = lwl_v;
      3'd6: ld_val = lwr_v;
      3'd7: ld_val = ld_data;
    endcase
  end

  assign is_load = ms_r.load_op != 3'd7;
  assign final_result = (ms_r.req_issued && is_load) ? ld_val
                                                     : ms_r.result;

  assign ms_to_ws_valid = !reset && ms_valid &&
                          ms_ready_go && !ms_flush;
  assign ms_to_ws_bus = {ms_r.ex, ms_r.gr_we, ms_r.dest,
                         final_result, ms_r.pc};

  assign MEM_dest   = ms_r.dest & {5{ms_valid && !reset}};
  assign MEM_result = final_result;
  assign MEM_stall  = !reset && ms_valid &&
                      ms_r.req_issued && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus a randomized stream
// checked against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_ms_valid;
  logic [108:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         data_data_ok;
  logic [31:0]  data_rdata;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [70:0]  ms_to_ws_bus;
  logic         ms_flush;
  logic [4:0]   MEM_dest;
  logic [31:0]  MEM_result;
  logic         MEM_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .ms_allowin     (ms_allowin),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_flush       (ms_flush),
    .MEM_dest       (MEM_dest),
    .MEM_result     (MEM_result),
    .MEM_stall      (MEM_stall)
  );

  typedef struct {
    logic        req;
    logic [2:0]  op;
    logic [1:0]  k;
    logic [31:0] rt;
    logic        ex;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] rdata;
  } txn_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    data_data_ok   = 1'b0;
    data_rdata     = 32'h0;
    ws_allowin     = 1'b1;
    ms_flush       = 1'b0;
  endtask

  // Load result from byte/halfword arithmetic on the word.
  function automatic logic [31:0] ref_load(
    logic [2:0] op, logic [1:0] k,
    logic [31:0] rt, logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] m;
    int n;
    n  = 8 * int'(k);
    sh = d >> n;
    case (op)
      3'd0: return d;
      3'd1: return {{24{sh[7]}}, sh[7:0]};
      3'd2: return {24'h0, sh[7:0]};
      3'd3: return k[0] ? 32'h0 : {{16{sh[15]}}, sh[15:0]};
      3'd4: return k[0] ? 32'h0 : {16'h0, sh[15:0]};
      3'd5: begin
        m = 32'hFFFF_FFFF >> (n + 8);
        return (d << (24 - n)) | (rt & m);
      end
      3'd6: begin
        m = 32'hFFFF_FFFF >> n;
        return sh | (rt & ~m);
      end
      default: return d;
    endcase
  endfunction

  function automatic logic [108:0] bus_of(txn_t t);
    return {t.req, t.op, t.k, t.rt, t.ex, t.we,
            t.dest, t.res, t.pc};
  endfunction

  function automatic logic [70:0] exp_bus(txn_t t);
    logic [31:0] r;
    r = (t.req && t.op != 3'd7)
      ? ref_load(t.op, t.k, t.rt, t.rdata) : t.res;
    return {t.ex, t.we, t.dest, r, t.pc};
  endfunction

  function automatic txn_t rand_txn(logic req);
    txn_t t;
    t.req   = req;
    t.op    = 3'($urandom_range(0, 7));
    t.k     = 2'($urandom_range(0, 3));
    t.rt    = $urandom;
    t.ex    = 1'($urandom_range(0, 1));
    t.we    = 1'($urandom_range(0, 1));
    t.dest  = 5'($urandom_range(1, 31));
    t.res   = $urandom;
    t.pc    = $urandom;
    t.rdata = $urandom;
    return t;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got %b want 0", ms_to_ws_valid);
    end
    checks++;
    if (MEM_stall !== 1'b0 || MEM_dest !== 5'd0) begin
      failures++;
      $display("FAIL rst_fwd got stall=%b dest=%0d want 0/0",
               MEM_stall, MEM_dest);
    end
    checks++;
    if (ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL rst_allowin got %b want 1", ms_allowin);
    end
    checks++;
    if (ms_to_ws_bus !== 71'h0) begin
      failures++;
      $display("FAIL rst_bus got %h want 0", ms_to_ws_bus);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [2:0]  ops  [3] = '{3'd1, 3'd6, 3'd4};
    logic [1:0]  ks   [3] = '{2'd2, 2'd1, 2'd2};
    logic [31:0] rts  [3] = '{32'h0BAD_F00D, 32'hAABB_CCDD,
                              32'hAABB_CCDD};
    logic [31:0] ds   [3] = '{32'h12F4_5678, 32'h1122_3344,
                              32'h1122_3344};
    logic [31:0] exps [3] = '{32'hFFFF_FFF4, 32'hAA11_2233,
                              32'h0000_1122};
    txn_t t;
    for (int i = 0; i < 3; i++) begin
      t = rand_txn(1'b1);
      t.op = ops[i];
      t.k  = ks[i];
      t.rt = rts[i];
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = bus_of(t);
      tick();
      es_to_ms_valid = 1'b0;
      data_data_ok   = 1'b1;
      data_rdata     = ds[i];
      ws_allowin     = 1'b1;
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b1) begin
        failures++;
        $display("FAIL vec%0d_valid got %b want 1", i,
                 ms_to_ws_valid);
      end
      checks++;
      if (ms_to_ws_bus[63:32] !== exps[i]) begin
        failures++;
        $display("FAIL vec%0d_result got %h want %h", i,
                 ms_to_ws_bus[63:32], exps[i]);
      end
      tick();
      data_data_ok = 1'b0;
    end
  endtask

  task automatic test_nonmem();
    txn_t t;
    for (int i = 0; i < 4; i++) begin
      t = rand_txn(1'b0);
      t.ex = 1'b1;
      t.we = 1'b1;
      t.dest = 5'd5;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = bus_of(t);
      tick();
      es_to_ms_valid = 1'b0;
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b1 ||
          ms_to_ws_bus !== {1'b1, 1'b1, 5'd5, t.res, t.pc}) begin
        failures++;
        $display("FAIL nonmem_pass got v=%b bus=%h want 1/%h",
                 ms_to_ws_valid, ms_to_ws_bus,
                 {1'b1, 1'b1, 5'd5, t.res, t.pc});
      end
      checks++;
      if (MEM_dest !== 5'd5 || MEM_stall !== 1'b0 ||
          MEM_result !== t.res) begin
        failures++;
        $display("FAIL nonmem_fwd got d=%0d s=%b r=%h want 5/0/%h",
                 MEM_dest, MEM_stall, MEM_result, t.res);
      end
      tick();
      checks++;
      if (ms_to_ws_valid !== 1'b0 || MEM_dest !== 5'd0) begin
        failures++;
        $display("FAIL nonmem_drain got v=%b d=%0d want 0/0",
                 ms_to_ws_valid, MEM_dest);
      end
    end
  endtask

  task automatic test_hold();
    txn_t t;
    int acc;
    t = rand_txn(1'b1);
    t.op = 3'($urandom_range(0, 6));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus_of(t);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (MEM_stall !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_wait got s=%b v=%b want 1/0",
               MEM_stall, ms_to_ws_valid);
    end
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      data_data_ok = (c == 0);
      data_rdata   = (c == 0) ? t.rdata : $urandom;
      ws_allowin   = (c == 3);
      #1;
      if (c <= 3) begin
        checks++;
        if (ms_to_ws_valid !== 1'b1 ||
            ms_to_ws_bus !== exp_bus(t)) begin
          failures++;
          $display("FAIL hold_c%0d got v=%b bus=%h want 1/%h", c,
                   ms_to_ws_valid, ms_to_ws_bus, exp_bus(t));
        end
        checks++;
        if (MEM_stall !== 1'b0) begin
          failures++;
          $display("FAIL hold_stall_c%0d got %b want 0", c,
                   MEM_stall);
        end
      end else begin
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin
          failures++;
          $display("FAIL hold_after got %b want 0", ms_to_ws_valid);
        end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (ms_allowin !== 1'b0) begin
          failures++;
          $display("FAIL hold_allowin_c%0d got %b want 0", c,
                   ms_allowin);
        end
      end
      if (ms_to_ws_valid && ws_allowin) acc++;
      tick();
    end
    checks++;
    if (acc != 1) begin
      failures++;
      $display("FAIL hold_pulses got %0d want 1", acc);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    txn_t t;
    txn_t t2;
    t = rand_txn(1'b1);
    t.op = 3'd0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus_of(t);
    tick();
    es_to_ms_valid = 1'b0;
    ms_flush = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid got %b want 0", ms_to_ws_valid);
    end
    tick();
    ms_flush = 1'b0;
    t2 = rand_txn(1'b1);
    t2.op = 3'($urandom_range(0, 6));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus_of(t2);
    #1;
    checks++;
    if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0 ||
        MEM_dest !== 5'd0) begin
      failures++;
      $display("FAIL cancel1 got a=%b v=%b d=%0d want 0/0/0",
               ms_allowin, ms_to_ws_valid, MEM_dest);
    end
    tick();
    data_data_ok = 1'b1;
    data_rdata   = t.rdata;
    #1;
    checks++;
    if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL cancel_drop got a=%b v=%b want 0/0",
               ms_allowin, ms_to_ws_valid);
    end
    tick();
    data_data_ok = 1'b0;
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL cancel_exit got %b want 1", ms_allowin);
    end
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (MEM_stall !== 1'b1) begin
      failures++;
      $display("FAIL next_stall got %b want 1", MEM_stall);
    end
    data_data_ok = 1'b1;
    data_rdata   = t2.rdata;
    ws_allowin   = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 ||
        ms_to_ws_bus !== exp_bus(t2)) begin
      failures++;
      $display("FAIL next_load got v=%b bus=%h want 1/%h",
               ms_to_ws_valid, ms_to_ws_bus, exp_bus(t2));
    end
    tick();
    data_data_ok = 1'b0;
    t = rand_txn(1'b1);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus_of(t);
    tick();
    es_to_ms_valid = 1'b0;
    data_data_ok   = 1'b1;
    data_rdata     = t.rdata;
    ws_allowin     = 1'b0;
    tick();
    data_data_ok = 1'b0;
    ms_flush     = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_hold got %b want 0", ms_to_ws_valid);
    end
    tick();
    ms_flush   = 1'b0;
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_hold_exit got a=%b v=%b want 1/0",
               ms_allowin, ms_to_ws_valid);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    txn_t mq[$];
    txn_t nxt;
    logic given;
    logic ready;
    logic exp_allow;
    logic exp_stall;
    logic dok;
    logic sendv;
    int   sent;
    int   acc;
    sent  = 0;
    acc   = 0;
    given = 1'b0;
    nxt   = rand_txn(1'($urandom_range(0, 1)));
    for (int cyc = 0; cyc < 300; cyc++) begin
      sendv = (cyc < 250) && ($urandom_range(0, 3) != 0);
      es_to_ms_valid = sendv;
      es_to_ms_bus   = bus_of(nxt);
      ws_allowin     = ($urandom_range(0, 3) != 0);
      dok = 1'b0;
      if (mq.size() != 0) begin
        if (mq[0].req && !given && $urandom_range(0, 2) == 0)
          dok = 1'b1;
      end
      data_data_ok = dok;
      data_rdata   = dok ? mq[0].rdata : $urandom;
      #1;
      ready = 1'b0;
      exp_stall = 1'b0;
      if (mq.size() != 0) begin
        ready = !mq[0].req || given || dok;
        exp_stall = mq[0].req && !ready;
      end
      exp_allow = (mq.size() == 0) || (ready && ws_allowin);
      checks++;
      if (ms_to_ws_valid !== ready) begin
        failures++;
        $display("FAIL b2b_valid cyc%0d got %b want %b", cyc,
                 ms_to_ws_valid, ready);
      end
      if (ready) begin
        checks++;
        if (ms_to_ws_bus !== exp_bus(mq[0])) begin
          failures++;
          $display("FAIL b2b_bus cyc%0d got %h want %h", cyc,
                   ms_to_ws_bus, exp_bus(mq[0]));
        end
      end
      checks++;
      if (ms_allowin !== exp_allow) begin
        failures++;
        $display("FAIL b2b_allowin cyc%0d got %b want %b", cyc,
                 ms_allowin, exp_allow);
      end
      checks++;
      if (MEM_stall !== exp_stall) begin
        failures++;
        $display("FAIL b2b_stall cyc%0d got %b want %b", cyc,
                 MEM_stall, exp_stall);
      end
      if (dok) given = 1'b1;
      if (ready && ws_allowin) begin
        void'(mq.pop_front());
        given = 1'b0;
        acc++;
      end
      if (sendv && exp_allow) begin
        mq.push_back(nxt);
        sent++;
        nxt = rand_txn(1'($urandom_range(0, 1)));
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (acc != sent || mq.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got acc=%0d left=%0d want %0d/0",
               acc, mq.size(), sent);
    end
  endtask

  task automatic test_reset_hold();
    txn_t t;
    t = rand_txn(1'b1);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus_of(t);
    tick();
    es_to_ms_valid = 1'b0;
    data_data_ok   = 1'b1;
    data_rdata     = t.rdata;
    ws_allowin     = 1'b0;
    tick();
    data_data_ok = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 ||
        MEM_dest !== 5'd0) begin
      failures++;
      $display("FAIL rsthold_during got v=%b a=%b d=%0d want 0/1/0",
               ms_to_ws_valid, ms_allowin, MEM_dest);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 ||
        MEM_dest !== 5'd0 || MEM_stall !== 1'b0) begin
      failures++;
      $display("FAIL rsthold_after got v=%b a=%b d=%0d s=%b",
               ms_to_ws_valid, ms_allowin, MEM_dest, MEM_stall);
    end
    t = rand_txn(1'b0);
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus_of(t);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 ||
        ms_to_ws_bus !== exp_bus(t)) begin
      failures++;
      $display("FAIL rsthold_idle got v=%b bus=%h want 1/%h",
               ms_to_ws_valid, ms_to_ws_bus, exp_bus(t));
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vectors();
    test_nonmem();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 es_to_ms_valid  input  1  EX stage holds a valid instruction for MEM.
REQ-004 es_to_ms_bus  input  109  fields, high to low:
- req_issued[108]: data request already sent by EX.
- load_op[107:105]: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lwl, 6 lwr.
- rdata_type[104:103]: address bits [1:0].
- rt_value[102:71], ex[70], gr_we[69], dest[68:64], result[63:32], pc[31:0].
REQ-005 ms_allowin  output  1  MEM can accept from EX this cycle.
REQ-006 data_data_ok  input  1  one-cycle pulse; read data of the oldest outstanding request is valid.
REQ-007 data_rdata  input  32  read data, valid with data_data_ok.
REQ-008 ws_allowin  input  1  WB can accept this cycle.
REQ-009 ms_to_ws_valid  output  1  MEM presents a completed instruction to WB.
REQ-010 ms_to_ws_bus  output  71  {ex[70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 ms_flush  input  1  discard the instruction held in MEM this cycle.
REQ-012 MEM_dest  output  5  forwarding address to ID; dest gated by ms_valid.
REQ-013 MEM_result  output  32  forwarding data to ID; equals final_result.
REQ-014 MEM_stall  output  1  load in MEM not yet complete; ID stalls a dependent instruction.

Function
REQ-015 Input register and ms_valid SHALL load on (es_to_ms_valid && ms_allowin); ms_valid <= es_to_ms_valid whenever ms_allowin.
REQ-016 FSM states:
- IDLE: no request outstanding.
- WAIT: req_issued && data not yet returned.
- HOLD: data returned, buffered, WB not accepting.
- CANCEL: flushed instruction with request still outstanding.
REQ-017 On capture with req_issued=1 the FSM SHALL enter WAIT; with req_issued=0 it SHALL stay IDLE.
REQ-018 WAIT transitions on data_data_ok:
- ws_allowin=1: IDLE; data consumed same cycle, zero added latency.
- ws_allowin=0: HOLD; data_rdata latched into a 32-bit buffer.
REQ-019 HOLD SHALL return to IDLE on the cycle ws_allowin=1.
REQ-020 ms_ready_go = (state==IDLE && !req_issued) || (state==WAIT && data_data_ok) || state==HOLD.
REQ-021 ms_allowin = (!ms_valid || (ms_ready_go && ws_allowin)) && state!=CANCEL.
REQ-022 ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush.
REQ-023 Load data SHALL be data_rdata when data_data_ok is high this cycle, else the HOLD buffer.
REQ-024 Load extraction, by rdata_type k = 0..3:
- lb: byte k sign-extended; lbu: byte k zero-extended.
- lh: halfword at k=0 or k=2, sign-extended; lhu: same, zero-extended; k=1 or k=3 yields 0.
- lwl: {rdata[8k+7:0], rt_value[23-8k:0]}; k=3 yields rdata.
- lwr: {rt_value[31:32-8k], rdata[31:8k]}; k=0 yields rdata.
- lw: rdata.
REQ-025 final_result SHALL be the extracted load data when req_issued && load_op is a load; otherwise result.
REQ-026 ex, gr_we, dest and pc SHALL pass through unchanged; MEM SHALL NOT alter the ex bit.
REQ-027 ms_flush SHALL clear ms_valid next cycle.
- If in WAIT without data_data_ok that cycle, or if a request is being captured that cycle: CANCEL.
- Otherwise: IDLE.
REQ-028 CANCEL SHALL drop the next data_data_ok and then return to IDLE; ms_allowin=0 throughout CANCEL.
REQ-029 MEM_stall = ms_valid && req_issued && !ms_ready_go.
REQ-030 MEM_dest = dest & {5{ms_valid}}.

Reset
REQ-031 On reset, the following SHALL clear to 0 on the next posedge: ms_valid, FSM (IDLE), input register, HOLD buffer.
REQ-032 During reset, ms_to_ws_valid=0, MEM_stall=0, MEM_dest=0, ms_allowin=1.
REQ-033 Reset in any state, CANCEL included, SHALL return to IDLE; a data_data_ok arriving after reset is not tracked by this block.

Verification
REQ-034 lb, rdata_type=2, data_data_ok with data_rdata=0x12F45678, ws_allowin=1 -> same cycle ms_to_ws_valid=1, final_result=0xFFFFFFF4.
REQ-035 lwr, rdata_type=1, rt_value=0xAABBCCDD, rdata=0x11223344 -> final_result=0xAA112233; lhu at rdata_type=2 on the same data -> 0x00001122.
REQ-036 Load in WAIT, data_data_ok while ws_allowin=0, ws_allowin=1 three cycles later -> HOLD; buffered data forwarded; MEM_stall=0 once data arrives; exactly one ms_to_ws_valid pulse.
REQ-037 ms_flush in WAIT, data_data_ok two cycles later -> no ms_to_ws_valid; ms_allowin=0 until the cycle after data_data_ok; the next load then uses its own data.
REQ-038 Non-memory instruction, ex=1, gr_we=1, dest=5 -> passes in one cycle, bus ex=1, result unchanged; MEM_dest=5 while ms_valid.
REQ-039 Reset asserted in HOLD -> next cycle ms_valid=0, IDLE, ms_allowin=1, MEM_dest=0.
